ram_burst_master: RTL and testbench

- Initiator side of the single-port synchronous RAM port: accepts burst read/write commands over a valid/ready interface and drives ram_we/ram_addr/ram_din.
- Returns read data over a valid/ready stream.
- Handles the RAM's 1-cycle registered read latency with a credit-limited 2-entry response buffer.
- Sits between a datapath client and one RAM instance that shares the same clk and rst.

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_rsp_buf.sv | 66 ++++++
 rtl/ram_burst_master.sv | 166 ++++++++++++++++
 tb/tb_ram_burst_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the RAM burst master and its response buffer:
// default address/data/length widths, response buffer depth and the
// burst FSM state encoding.
package ram_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_LEN_W  = 6;

    // The RAM has a one-cycle registered read, so two entries are enough
    // to cover one beat being popped while the next one lands.
    localparam int RSP_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/ram_rsp_buf.sv
// ram_rsp_buf
// Two-entry synchronous FIFO holding read data returned by the RAM until
// the client consumes it. The head entry is always visible on o_popData.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears storage)
//   i_push       : write i_pushData into the tail this cycle
//   i_pushData   : data to store
//   i_pop        : drop the head entry this cycle
//   o_popData    : current head entry
//   o_valid      : FIFO holds at least one entry
//   o_count      : number of entries held (0..2)
module ram_rsp_buf
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_pushData,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_popData,
    output logic              o_valid,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [RSP_DEPTH];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_count;
    logic              w_doPop;
    logic              w_doPush;

    // A pop on an empty buffer or a push on a full one (without a
    // simultaneous pop) is ignored so the pointers can never corrupt.
    assign w_doPop  = i_pop && (r_count != 2'd0);
    assign w_doPush = i_push && ((r_count != 2'd2) || w_doPop);

    assign o_popData = r_mem[r_rdPtr];
    assign o_valid   = (r_count != 2'd0);
    assign o_count   = r_count;

    // Storage, pointers and occupancy. Storage is cleared on reset so the
    // head reads as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_pushData;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + 2'(w_doPush) - 2'(w_doPop);
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master
// Initiator for a single-port synchronous RAM with a one-cycle registered
// read. Accepts burst read/write commands, streams write beats into the
// RAM and returns read beats in order through a 2-entry response buffer.
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready        : command handshake
//   i_cmd_write                    : 1 = write burst, 0 = read burst
//   i_cmd_addr, i_cmd_len          : start address, beats minus one
//   i_wr_valid/i_wr_data/o_wr_ready: write beat stream
//   o_rd_valid/o_rd_data/i_rd_ready: read beat stream
//   o_busy                         : a burst is in progress
//   o_done                         : one-cycle pulse after a burst completes
//   o_ram_we/o_ram_addr/o_ram_din  : RAM request
//   i_ram_dout                     : RAM registered read data
module ram_burst_master
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int LEN_W  = RAM_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_rd_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout
);

    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W:0]    r_issueLeft;
    logic [LEN_W:0]    r_popLeft;
    logic              r_inflight;
    logic              r_done;

    logic              w_cmdFire;
    logic              w_wrFire;
    logic              w_issue;
    logic              w_pop;
    logic              w_finish;
    logic [1:0]        w_bufCount;
    logic [2:0]        w_occupancy;
    logic [LEN_W:0]    w_beats;

    ram_rsp_buf #(
        .DATA_W (DATA_W)
    ) u_rspBuf (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_inflight),
        .i_pushData (i_ram_dout),
        .i_pop      (w_pop),
        .o_popData  (o_rd_data),
        .o_valid    (o_rd_valid),
        .o_count    (w_bufCount)
    );

    assign w_beats   = (LEN_W+1)'(i_cmd_len) + (LEN_W+1)'(1);
    assign w_cmdFire = (r_state == ST_IDLE) && i_cmd_valid;
    assign w_wrFire  = (r_state == ST_WR) && i_wr_valid;
    assign w_pop     = o_rd_valid && i_rd_ready;

    // Credit seen by the issue logic: entries held plus the beat in the
    // RAM pipeline, minus the entry leaving this cycle. Counting the pop
    // keeps a full-rate stream going when rd_ready stays high, and it is
    // still safe because the pop is committed at the same edge.
    assign w_occupancy = {1'b0, w_bufCount} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_ram_addr = r_addr;
    assign o_ram_din  = i_wr_data;

    // Next-state and handshake outputs. The FSM returns to IDLE on the
    // edge that consumes the final write beat or pops the final read beat.
    always_comb begin
        w_stateNext = r_state;
        o_cmd_ready = 1'b0;
        o_wr_ready  = 1'b0;
        o_ram_we    = 1'b0;
        w_issue     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_stateNext = i_cmd_write ? ST_WR : ST_RD_ISSUE;
                end
            end
            ST_WR: begin
                o_wr_ready = 1'b1;
                o_ram_we   = i_wr_valid;
                if (i_wr_valid && (r_issueLeft == (LEN_W+1)'(1))) begin
                    w_stateNext = ST_IDLE;
                    w_finish    = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                if (w_occupancy < 3'd2) begin
                    w_issue = 1'b1;
                    if (r_issueLeft == (LEN_W+1)'(1)) begin
                        w_stateNext = ST_RD_DRAIN;
                    end
                end
            end
            ST_RD_DRAIN: begin
                if (w_pop && (r_popLeft == (LEN_W+1)'(1))) begin
                    w_stateNext = ST_IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State, address/beat counters, in-flight flag and the done pulse.
    // r_issueLeft counts beats still to write or issue; r_popLeft counts
    // read beats the client has not yet taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_issueLeft <= '0;
            r_popLeft   <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_done     <= w_finish;
            r_inflight <= w_issue;
            if (w_cmdFire) begin
                r_addr      <= i_cmd_addr;
                r_issueLeft <= w_beats;
                r_popLeft   <= w_beats;
            end else begin
                if (w_wrFire || w_issue) begin
                    r_addr      <= r_addr + ADDR_W'(1);
                    r_issueLeft <= r_issueLeft - (LEN_W+1)'(1);
                end
                if (w_pop) begin
                    r_popLeft <= r_popLeft - (LEN_W+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master
// Drives ram_burst_master against a behavioural single-port RAM and
// compares every observed beat with an expected memory image the bench
// maintains from the bursts it has commanded.
module tb_ram_burst_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmdValid;
    logic       cmdReady;
    logic       cmdWrite;
    logic [5:0] cmdAddr;
    logic [5:0] cmdLen;
    logic       wrValid;
    logic [7:0] wrData;
    logic       wrReady;
    logic       rdValid;
    logic [7:0] rdData;
    logic       rdReady;
    logic       busy;
    logic       done;
    logic       ramWe;
    logic [5:0] ramAddr;
    logic [7:0] ramDin;
    logic [7:0] ramDout;

    logic [7:0] ramMem [64];
    logic [7:0] refMem [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_burst_master dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (cmdValid),
        .o_cmd_ready (cmdReady),
        .i_cmd_write (cmdWrite),
        .i_cmd_addr  (cmdAddr),
        .i_cmd_len   (cmdLen),
        .i_wr_valid  (wrValid),
        .i_wr_data   (wrData),
        .o_wr_ready  (wrReady),
        .o_rd_valid  (rdValid),
        .o_rd_data   (rdData),
        .i_rd_ready  (rdReady),
        .o_busy      (busy),
        .o_done      (done),
        .o_ram_we    (ramWe),
        .o_ram_addr  (ramAddr),
        .o_ram_din   (ramDin),
        .i_ram_dout  (ramDout)
    );

    // Behavioural RAM: registered read, write-enable, cleared by rst.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ramMem[i] <= 8'h00;
            ramDout <= 8'h00;
        end else begin
            if (ramWe) ramMem[ramAddr] <= ramDin;
            ramDout <= ramMem[ramAddr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clearRef();
        for (int i = 0; i < 64; i++) refMem[i] = 8'h00;
    endtask

    // Hold reset for the given number of cycles and check reset values.
    task automatic applyReset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        #1;
        checkOutput("rst_cmd_ready", cmdReady, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rd_valid", rdValid, 0);
        checkOutput("rst_rd_data", rdData, 0);
        checkOutput("rst_ram_we", ramWe, 0);
        checkOutput("rst_ram_addr", ramAddr, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_wr_ready", wrReady, 0);
        rst = 1'b0;
        clearRef();
    endtask

    // gapMode: 0 = beat every cycle, 1 = alternate gaps, 2 = random gaps.
    // dataBase < 0 selects random data, otherwise beat i carries dataBase+i.
    task automatic writeBurst(input int addr, input int len, input int gapMode, input int dataBase);
        int beat;
        int cycles;
        logic [7:0] d;
        @(negedge clk);
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 6'(addr); cmdLen = 6'(len);
        #1 checkOutput("wr_cmd_ready", cmdReady, 1);
        @(negedge clk);
        cmdValid = 1'b0;
        beat = 0;
        cycles = 0;
        while (beat <= len && cycles < 1000) begin
            case (gapMode)
                0: wrValid = 1'b1;
                1: wrValid = (cycles % 2 == 0);
                default: wrValid = ($urandom_range(99) >= 35);
            endcase
            d = (dataBase < 0) ? 8'($urandom) : 8'(dataBase + beat);
            wrData = d;
            #1;
            checkOutput("wr_ready", wrReady, 1);
            checkOutput("wr_we", ramWe, wrValid);
            checkOutput("wr_done_early", done, 0);
            if (wrValid) begin
                checkOutput("wr_addr", ramAddr, (addr + beat) % 64);
                checkOutput("wr_din", ramDin, d);
                refMem[(addr + beat) % 64] = d;
                beat++;
            end
            @(negedge clk);
            cycles++;
        end
        wrValid = 1'b0;
        if (cycles >= 1000) checkOutput("wr_timeout", beat, len + 1);
        #1;
        checkOutput("wr_done", done, 1);
        checkOutput("wr_cmd_ready_after", cmdReady, 1);
        checkOutput("wr_busy_after", busy, 0);
        @(negedge clk);
        #1 checkOutput("wr_done_once", done, 0);
    endtask

    // readyMode: 0 = always ready, 1 = random, 2 = 5-cycle stall window.
    task automatic readBurst(input int addr, input int len, input int readyMode);
        int edges;
        int popped;
        int issued;
        bit firstSeen;
        @(negedge clk);
        cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 6'(addr); cmdLen = 6'(len);
        rdReady = 1'b0;
        #1 checkOutput("rd_cmd_ready", cmdReady, 1);
        @(negedge clk);
        cmdValid = 1'b0;
        edges = 0;
        popped = 0;
        firstSeen = 1'b0;
        while (popped <= len && edges < 2000) begin
            case (readyMode)
                0: rdReady = 1'b1;
                1: rdReady = ($urandom_range(99) < 70);
                default: rdReady = !(edges >= 4 && edges <= 8);
            endcase
            #1;
            checkOutput("rd_ram_we", ramWe, 0);
            checkOutput("rd_busy", busy, 1);
            checkOutput("rd_done_early", done, 0);
            if (len < 63) begin
                issued = (int'(ramAddr) - addr + 64) % 64;
                checkOutput("rd_outstanding_le2", (issued - popped) <= 2, 1);
            end
            if (rdValid && !firstSeen) begin
                firstSeen = 1'b1;
                checkOutput("rd_latency", edges, 2);
            end
            if (rdValid && rdReady) begin
                checkOutput("rd_data", rdData, refMem[(addr + popped) % 64]);
                popped++;
            end
            @(negedge clk);
            edges++;
        end
        rdReady = 1'b0;
        if (edges >= 2000) checkOutput("rd_timeout", popped, len + 1);
        #1;
        checkOutput("rd_done", done, 1);
        checkOutput("rd_cmd_ready_after", cmdReady, 1);
        checkOutput("rd_valid_after", rdValid, 0);
        @(negedge clk);
        #1 checkOutput("rd_done_once", done, 0);
    endtask

    // Reset while the third beat of a 6-beat read is on the output.
    task automatic resetMidRead(input int addr);
        int popped;
        int edges;
        @(negedge clk);
        cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 6'(addr); cmdLen = 6'd5;
        @(negedge clk);
        cmdValid = 1'b0;
        rdReady = 1'b1;
        popped = 0;
        edges = 0;
        while (popped < 2 && edges < 100) begin
            #1;
            if (rdValid) popped++;
            @(negedge clk);
            edges++;
        end
        #1;
        checkOutput("mid_third_beat_valid", rdValid, 1);
        checkOutput("mid_third_beat_data", rdData, refMem[(addr + 2) % 64]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdReady = 1'b0;
        clearRef();
        #1;
        checkOutput("mid_rst_rd_valid", rdValid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_cmd_ready", cmdReady, 1);
        checkOutput("mid_rst_ram_addr", ramAddr, 0);
        checkOutput("mid_rst_done", done, 0);
        repeat (3) begin
            @(negedge clk);
            #1 checkOutput("mid_rst_no_stale_valid", rdValid, 0);
        end
    endtask

    task automatic applyStimulus();
        int a;
        int l;
        applyReset(2);

        writeBurst(5, 3, 0, 8'hA0);
        readBurst(5, 3, 0);

        writeBurst(20, 7, 0, -1);
        readBurst(20, 7, 2);

        writeBurst(62, 3, 1, 8'hB0);
        readBurst(62, 3, 0);

        writeBurst(33, 0, 0, 8'h5A);
        readBurst(33, 0, 1);

        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(63);
            l = $urandom_range(12);
            writeBurst(a, l, 2, -1);
            readBurst(a, l, int'($urandom_range(2)));
        end

        writeBurst(40, 5, 0, 8'hC1);
        resetMidRead(40);
        readBurst(40, 5, 0);
    endtask

    initial begin
        rst = 1'b1;
        cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdLen = '0;
        wrValid = 1'b0; wrData = '0; rdReady = 1'b0;
        clearRef();
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
